// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main controller.
// Steps each instruction through FETCH/DECODE/execute/writeback states and
// drives the datapath mux selects and write enables from the current state.
// Memory states (FETCH, MEMRD, MEMWR) stretch by MEM_WAIT extra cycles.
module multicycle_control #(
  parameter int OPW      = 6,
  parameter int ALUOPW   = 2,
  parameter int MEM_WAIT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OPW-1:0]    opcode,
  input  logic              zero,
  output logic              pc_en,
  output logic              ir_write,
  output logic              iord,
  output logic              mem_write,
  output logic              reg_write,
  output logic              reg_dst,
  output logic              mem_to_reg,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [ALUOPW-1:0] alu_op,
  output logic [1:0]        pc_src,
  output logic [3:0]        state,
  output logic              instr_done,
  output logic              illegal
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_BNE    = 4'd9,
    S_IMMEX  = 4'd10,
    S_LUIEX  = 4'd11,
    S_IMMWB  = 4'd12,
    S_JUMP   = 4'd13
  } state_t;

  localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_R    = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_BNE  = OPW'(6'b000101);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_LUI  = OPW'(6'b001111);
  localparam logic [OPW-1:0] OP_J    = OPW'(6'b000010);

  localparam logic [ALUOPW-1:0] ALU_FUNCT = '0;
  localparam logic [ALUOPW-1:0] ALU_SUB   = ALUOPW'(1);
  localparam logic [ALUOPW-1:0] ALU_ADD   = ALUOPW'(2);
  localparam logic [ALUOPW-1:0] ALU_LUI   = ALUOPW'(3);

  localparam logic [3:0] WAIT_MAX = 4'(MEM_WAIT);

  state_t     r_state;
  logic [3:0] r_wcnt;
  logic       r_is_sw;
  logic       w_wait_done;
  state_t     w_view;

  assign w_wait_done = (r_wcnt == WAIT_MAX);
  assign state       = r_state;

  // State sequencing and memory wait counter; the wait counter is zero on entry to every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_wcnt  <= '0;
      r_is_sw <= 1'b0;
    end else begin
      r_wcnt <= '0;
      case (r_state)
        S_FETCH: begin
          if (w_wait_done) r_state <= S_DECODE;
          else             r_wcnt  <= r_wcnt + 4'd1;
        end
        S_DECODE: begin
          case (opcode)
            OP_LW:   begin r_state <= S_MEMADR; r_is_sw <= 1'b0; end
            OP_SW:   begin r_state <= S_MEMADR; r_is_sw <= 1'b1; end
            OP_R:    r_state <= S_EXEC;
            OP_BEQ:  r_state <= S_BEQ;
            OP_BNE:  r_state <= S_BNE;
            OP_ADDI: r_state <= S_IMMEX;
            OP_LUI:  r_state <= S_LUIEX;
            OP_J:    r_state <= S_JUMP;
            default: r_state <= S_FETCH;
          endcase
        end
        S_MEMADR: r_state <= r_is_sw ? S_MEMWR : S_MEMRD;
        S_MEMRD: begin
          if (w_wait_done) r_state <= S_MEMWB;
          else             r_wcnt  <= r_wcnt + 4'd1;
        end
        S_MEMWR: begin
          if (w_wait_done) r_state <= S_FETCH;
          else             r_wcnt  <= r_wcnt + 4'd1;
        end
        S_EXEC:  r_state <= S_ALUWB;
        S_IMMEX: r_state <= S_IMMWB;
        S_LUIEX: r_state <= S_IMMWB;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // While reset is high the outputs decode as FETCH, then every write enable and strobe is masked.
  assign w_view = reset ? S_FETCH : r_state;

  // Datapath control decode from the current state, wait counter and zero flag.
  always_comb begin
    pc_en      = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = ALU_FUNCT;
    pc_src     = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (w_view)
      S_FETCH: begin
        alu_src_b = 2'b01;
        alu_op    = ALU_ADD;
        ir_write  = w_wait_done;
        pc_en     = w_wait_done;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW, OP_R, OP_BEQ, OP_BNE, OP_ADDI, OP_LUI, OP_J: illegal = 1'b0;
          default: illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        instr_done = w_wait_done;
      end
      S_EXEC: alu_src_a = 1'b1;
      S_ALUWB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ, S_BNE: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_src     = 2'b01;
        pc_en      = (w_view == S_BEQ) ? zero : ~zero;
        instr_done = 1'b1;
      end
      S_IMMEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
      end
      S_LUIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_LUI;
      end
      S_IMMWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_en      = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      pc_en      = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule
